// File: rtl/switch_allocator_pkg.sv
// Shared codes and helpers for the 5-port mesh router switch allocator.
package switch_allocator_pkg;

  localparam int unsigned NUM_PORTS = 5;

  // Routed output-port codes as produced by route compute.
  localparam int unsigned PN_L = 1;
  localparam int unsigned PN_E = 2;
  localparam int unsigned PN_N = 3;
  localparam int unsigned PN_W = 4;
  localparam int unsigned PN_S = 5;

  localparam logic [1:0] FT_HDR    = 2'b10;
  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_TAIL   = 2'b01;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } out_state_t;

  // Header and single-flit packets both open a packet.
  function automatic logic is_head(input logic [1:0] ft);
    return ft[1];
  endfunction

  // Tail and single-flit packets both close a packet.
  function automatic logic ends_packet(input logic [1:0] ft);
    return ft[0];
  endfunction

  function automatic logic [2:0] next_ptr(input logic [2:0] idx);
    return (idx == 3'd4) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/switch_allocator_rr_arbiter5.sv
// Combinational 5-way round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter5
  import switch_allocator_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [4:0] grant,
  output logic [2:0] idx
);

  logic [3:0] cand;
  logic       found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= 4'(NUM_PORTS)) begin
        cand = cand - 4'(NUM_PORTS);
      end
      if (!found && req[cand[2:0]]) begin
        found             = 1'b1;
        grant[cand[2:0]]  = 1'b1;
        idx               = cand[2:0];
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-output round-robin allocation with wormhole lock until the tail transfers.
module switch_allocator #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned PORT_W    = 4,
  parameter int unsigned SEL_W     = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [2*NUM_PORTS-1:0]      in_flit_type,
  input  logic [PORT_W*NUM_PORTS-1:0] in_port_num,
  input  logic [NUM_PORTS-1:0]        out_ready,
  output logic [NUM_PORTS-1:0]        in_grant,
  output logic [NUM_PORTS-1:0]        out_valid,
  output logic [SEL_W*NUM_PORTS-1:0]  out_sel,
  output logic [NUM_PORTS-1:0]        out_busy,
  output logic                        proto_err
);
  import switch_allocator_pkg::*;

  if (NUM_PORTS != switch_allocator_pkg::NUM_PORTS || SEL_W != 3 || PORT_W < 3) begin : g_bad_cfg
    $error("switch_allocator: only NUM_PORTS=5, SEL_W=3, PORT_W>=3 supported");
  end

  out_state_t           state_q   [NUM_PORTS];
  logic [SEL_W-1:0]     owner_q   [NUM_PORTS];
  logic [SEL_W-1:0]     ptr_q     [NUM_PORTS];

  logic [1:0]           ftype     [NUM_PORTS];
  logic [PORT_W-1:0]    pnum      [NUM_PORTS];
  logic [NUM_PORTS-1:0] req       [NUM_PORTS];
  logic [NUM_PORTS-1:0] arb_grant [NUM_PORTS];
  logic [SEL_W-1:0]     arb_idx   [NUM_PORTS];
  logic [NUM_PORTS-1:0] release_now;
  logic                 err_now;

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      ftype[i] = in_flit_type[2*i +: 2];
      pnum[i]  = in_port_num[PORT_W*i +: PORT_W];
    end
  end

  // Everything driven toward the crossbar and inputs comes from the lock state.
  always_comb begin
    in_grant    = '0;
    out_valid   = '0;
    out_sel     = '0;
    out_busy    = '0;
    release_now = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      if (state_q[o] == ST_LOCKED) begin
        out_busy[o]                = 1'b1;
        out_sel[SEL_W*o +: SEL_W]  = owner_q[o];
        in_grant[owner_q[o]]       = 1'b1;
        out_valid[o]               = in_valid[owner_q[o]];
        release_now[o]             = in_valid[owner_q[o]] && out_ready[o] &&
                                     ends_packet(ftype[owner_q[o]]);
      end
    end
  end

  always_comb begin
    err_now = 1'b0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      req[o] = '0;
    end
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (in_valid[i]) begin
        if (is_head(ftype[i])) begin
          if (pnum[i] < PORT_W'(PN_L) || pnum[i] > PORT_W'(PN_S)) begin
            err_now = 1'b1;
          end else if (!in_grant[i]) begin
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
              if (pnum[i] == PORT_W'(o + 1)) begin
                req[o][i] = 1'b1;
              end
            end
          end
        end else if (!in_grant[i]) begin
          err_now = 1'b1;
        end
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    rr_arbiter5 u_arb (
      .req   (req[o]),
      .ptr   (ptr_q[o]),
      .grant (arb_grant[o]),
      .idx   (arb_idx[o])
    );
  end

  // A releasing output only rejoins arbitration on the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= ST_IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
      proto_err <= 1'b0;
    end else begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        if (state_q[o] == ST_IDLE) begin
          if (|arb_grant[o]) begin
            state_q[o] <= ST_LOCKED;
            owner_q[o] <= arb_idx[o];
          end
        end else if (release_now[o]) begin
          state_q[o] <= ST_IDLE;
          ptr_q[o]   <= next_ptr(owner_q[o]);
        end
      end
      if (err_now) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed scenarios plus randomized traffic against a packet-level allocator model.
module tb_switch_allocator;
  import switch_allocator_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  in_valid;
  logic [9:0]  in_flit_type;
  logic [19:0] in_port_num;
  logic [4:0]  out_ready;
  logic [4:0]  in_grant;
  logic [4:0]  out_valid;
  logic [14:0] out_sel;
  logic [4:0]  out_busy;
  logic        proto_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  switch_allocator #(.NUM_PORTS(5), .PORT_W(4), .SEL_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_flit_type (in_flit_type),
    .in_port_num  (in_port_num),
    .out_ready    (out_ready),
    .in_grant     (in_grant),
    .out_valid    (out_valid),
    .out_sel      (out_sel),
    .out_busy     (out_busy),
    .proto_err    (proto_err)
  );

  task automatic drive(input int i, input logic v, input logic [1:0] ft, input logic [3:0] pn);
    in_valid[i]          = v;
    in_flit_type[2*i +: 2] = ft;
    in_port_num[4*i +: 4]  = pn;
  endtask

  task automatic idle_inputs();
    in_valid     = '0;
    in_flit_type = '0;
    in_port_num  = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    out_ready = '1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    out_ready = '1;
    idle_inputs();
    drive(0, 1'b1, FT_HDR, 4'd1);
    drive(1, 1'b1, FT_BODY, 4'd2);
    repeat (2) @(posedge clk);
    settle();
    total++; if (in_grant !== 5'b0) begin bad++; $display("FAIL reset_grant got=%b exp=%b", in_grant, 5'b0); end
    total++; if (out_busy !== 5'b0) begin bad++; $display("FAIL reset_busy got=%b exp=%b", out_busy, 5'b0); end
    total++; if (out_valid !== 5'b0) begin bad++; $display("FAIL reset_valid got=%b exp=%b", out_valid, 5'b0); end
    total++; if (out_sel !== 15'b0) begin bad++; $display("FAIL reset_sel got=%h exp=%h", out_sel, 15'b0); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=%b", proto_err, 1'b0); end
  endtask

  task automatic test_single_packet();
    int xfers;
    do_reset();
    xfers = 0;
    drive(0, 1'b1, FT_HDR, 4'd2);
    settle();
    total++; if (in_grant !== 5'b0) begin bad++; $display("FAIL single_c0_grant got=%b exp=%b", in_grant, 5'b0); end
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      if (c == 2 || c == 3) drive(0, 1'b1, FT_BODY, 4'd2);
      else if (c == 4)      drive(0, 1'b1, FT_TAIL, 4'd2);
      else if (c == 5)      idle_inputs();
      settle();
      if (c <= 4) begin
        total++; if (in_grant !== 5'b00001) begin bad++; $display("FAIL single_grant c=%0d got=%b exp=%b", c, in_grant, 5'b00001); end
        total++; if (out_busy !== 5'b00010) begin bad++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, out_busy, 5'b00010); end
        total++; if (out_sel[5:3] !== 3'd0) begin bad++; $display("FAIL single_sel c=%0d got=%0d exp=0", c, out_sel[5:3]); end
      end else begin
        total++; if (out_busy !== 5'b0) begin bad++; $display("FAIL single_release got=%b exp=%b", out_busy, 5'b0); end
      end
      if (out_valid[1] && out_ready[1]) xfers++;
    end
    total++; if (xfers != 4) begin bad++; $display("FAIL single_xfers got=%0d exp=4", xfers); end
  endtask

  task automatic test_contention();
    int st [5];
    int exp_own [10] = '{-1, 1, 1, -1, 3, 3, -1, 4, 4, -1};
    logic [4:0]  eg;
    logic [14:0] es;
    do_reset();
    st = '{default: 0};
    for (int c = 0; c < 10; c++) begin
      if (c > 0) next_cycle();
      foreach (st[i]) if (i == 1 || i == 3 || i == 4)
        drive(i, st[i] < 2, (st[i] == 0) ? FT_HDR : FT_TAIL, 4'd5);
      settle();
      eg = '0;
      es = '0;
      if (exp_own[c] >= 0) begin
        eg[exp_own[c]] = 1'b1;
        es[12 +: 3]    = 3'(exp_own[c]);
      end
      total++; if (in_grant !== eg) begin bad++; $display("FAIL cont_grant c=%0d got=%b exp=%b", c, in_grant, eg); end
      total++; if (out_sel !== es) begin bad++; $display("FAIL cont_sel c=%0d got=%h exp=%h", c, out_sel, es); end
      total++; if (out_busy !== ((exp_own[c] >= 0) ? 5'b10000 : 5'b0)) begin
        bad++; $display("FAIL cont_busy c=%0d got=%b", c, out_busy); end
      foreach (st[i]) if (in_grant[i] && out_ready[4] && st[i] < 2) st[i]++;
    end
    // pointer wrapped back to 0 after input 4 released
    next_cycle();
    idle_inputs();
    drive(0, 1'b1, FT_SINGLE, 4'd5);
    drive(2, 1'b1, FT_SINGLE, 4'd5);
    next_cycle();
    settle();
    total++; if (in_grant !== 5'b00001) begin bad++; $display("FAIL cont_ptr_wrap got=%b exp=%b", in_grant, 5'b00001); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_backpressure();
    int st0, st2, xfers;
    int exp_own [10] = '{-1, 0, 0, 0, 0, 0, 0, -1, 2, 2};
    logic [4:0]  eg;
    logic [14:0] es;
    do_reset();
    st0 = 0; st2 = 0; xfers = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) next_cycle();
      out_ready = (c >= 1 && c <= 3) ? 5'b11011 : 5'b11111;
      drive(0, st0 < 3, (st0 == 0) ? FT_HDR : (st0 == 1) ? FT_BODY : FT_TAIL, 4'd3);
      if (c >= 1) drive(2, st2 < 2, (st2 == 0) ? FT_HDR : FT_TAIL, 4'd3);
      settle();
      eg = '0;
      es = '0;
      if (exp_own[c] >= 0) begin
        eg[exp_own[c]] = 1'b1;
        es[6 +: 3]     = 3'(exp_own[c]);
      end
      total++; if (in_grant !== eg) begin bad++; $display("FAIL bp_grant c=%0d got=%b exp=%b", c, in_grant, eg); end
      total++; if (out_sel !== es) begin bad++; $display("FAIL bp_sel c=%0d got=%h exp=%h", c, out_sel, es); end
      total++; if (out_valid !== ((exp_own[c] >= 0) ? 5'b00100 : 5'b0)) begin
        bad++; $display("FAIL bp_valid c=%0d got=%b", c, out_valid); end
      if (in_grant[0] && out_valid[2] && out_ready[2]) xfers++;
      if (in_grant[0] && out_ready[2] && st0 < 3) st0++;
      if (in_grant[2] && out_ready[2] && st2 < 2) st2++;
    end
    total++; if (xfers != 3) begin bad++; $display("FAIL bp_xfers got=%0d exp=3", xfers); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_parallel();
    do_reset();
    drive(0, 1'b1, FT_SINGLE, 4'd3);
    drive(2, 1'b1, FT_SINGLE, 4'd1);
    next_cycle();
    settle();
    total++; if (in_grant !== 5'b00101) begin bad++; $display("FAIL par_grant got=%b exp=%b", in_grant, 5'b00101); end
    total++; if (out_busy !== 5'b00101) begin bad++; $display("FAIL par_busy got=%b exp=%b", out_busy, 5'b00101); end
    total++; if (out_sel !== 15'b000_000_000_000_010) begin bad++; $display("FAIL par_sel got=%h exp=%h", out_sel, 15'h0002); end
    next_cycle();
    idle_inputs();
    settle();
    total++; if (out_busy !== 5'b0) begin bad++; $display("FAIL par_release got=%b exp=%b", out_busy, 5'b0); end
  endtask

  task automatic test_errors();
    do_reset();
    drive(4, 1'b1, FT_HDR, 4'd0);
    drive(1, 1'b1, FT_BODY, 4'd2);
    settle();
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL err_before got=%b exp=0", proto_err); end
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      settle();
      total++; if (in_grant !== 5'b0) begin bad++; $display("FAIL err_grant c=%0d got=%b exp=%b", c, in_grant, 5'b0); end
      total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL err_set c=%0d got=%b exp=1", c, proto_err); end
    end
    next_cycle();
    idle_inputs();
    repeat (3) next_cycle();
    settle();
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", proto_err); end
    total++; if (out_busy !== 5'b0) begin bad++; $display("FAIL err_busy got=%b exp=%b", out_busy, 5'b0); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    drive(3, 1'b1, FT_HDR, 4'd2);
    next_cycle();
    settle();
    total++; if (in_grant !== 5'b01000) begin bad++; $display("FAIL rmp_first got=%b exp=%b", in_grant, 5'b01000); end
    next_cycle();
    drive(3, 1'b1, FT_TAIL, 4'd2);
    next_cycle();
    drive(3, 1'b0, FT_BODY, 4'd0);
    drive(0, 1'b1, FT_HDR, 4'd2);
    settle();
    total++; if (out_busy !== 5'b0) begin bad++; $display("FAIL rmp_gap got=%b exp=%b", out_busy, 5'b0); end
    next_cycle();
    next_cycle();
    drive(0, 1'b1, FT_BODY, 4'd2);
    settle();
    total++; if (out_busy !== 5'b00010) begin bad++; $display("FAIL rmp_locked got=%b exp=%b", out_busy, 5'b00010); end
    #1 rst = 1'b0;
    #1;
    total++; if (in_grant !== 5'b0) begin bad++; $display("FAIL rmp_grant got=%b exp=%b", in_grant, 5'b0); end
    total++; if (out_busy !== 5'b0) begin bad++; $display("FAIL rmp_busy got=%b exp=%b", out_busy, 5'b0); end
    total++; if (out_valid !== 5'b0) begin bad++; $display("FAIL rmp_valid got=%b exp=%b", out_valid, 5'b0); end
    total++; if (out_sel !== 15'b0) begin bad++; $display("FAIL rmp_sel got=%h exp=%h", out_sel, 15'b0); end
    next_cycle();
    idle_inputs();
    rst = 1'b1;
    drive(4, 1'b1, FT_HDR, 4'd2);
    drive(1, 1'b1, FT_HDR, 4'd2);
    next_cycle();
    settle();
    total++; if (in_grant !== 5'b00010) begin bad++; $display("FAIL rmp_ptr got=%b exp=%b", in_grant, 5'b00010); end
    total++; if (out_sel[5:3] !== 3'd1) begin bad++; $display("FAIL rmp_ptr_sel got=%0d exp=1", out_sel[5:3]); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_random();
    int own [5];
    int ptr [5];
    int dest [5];
    int len [5];
    int pos [5];
    bit act [5];
    bit dv [5];
    logic [1:0]  dft [5];
    logic [4:0]  eg, ev, eb;
    logic [14:0] es;
    int win;
    do_reset();
    own = '{default: -1};
    ptr = '{default: 0};
    act = '{default: 0};
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc > 0) next_cycle();
      for (int o = 0; o < 5; o++) out_ready[o] = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 5; i++) begin
        if (!act[i] && $urandom_range(0, 3) == 0) begin
          act[i]  = 1'b1;
          dest[i] = $urandom_range(1, 5);
          len[i]  = $urandom_range(1, 4);
          pos[i]  = 0;
        end
        if (act[i]) begin
          dv[i]  = ($urandom_range(0, 4) != 0);
          dft[i] = (len[i] == 1) ? FT_SINGLE : (pos[i] == 0) ? FT_HDR :
                   (pos[i] == len[i] - 1) ? FT_TAIL : FT_BODY;
          drive(i, dv[i], dft[i], 4'(dest[i]));
        end else begin
          dv[i]  = 1'b0;
          dft[i] = 2'($urandom_range(0, 3));
          drive(i, 1'b0, dft[i], 4'($urandom_range(0, 15)));
        end
      end
      eg = '0; ev = '0; eb = '0; es = '0;
      for (int o = 0; o < 5; o++) begin
        if (own[o] >= 0) begin
          eg[own[o]]  = 1'b1;
          eb[o]       = 1'b1;
          ev[o]       = dv[own[o]];
          es[3*o +: 3] = 3'(own[o]);
        end
      end
      settle();
      total++; if (in_grant !== eg) begin bad++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, in_grant, eg); end
      total++; if (out_valid !== ev) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_valid, ev); end
      total++; if (out_busy !== eb) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, out_busy, eb); end
      total++; if (out_sel !== es) begin bad++; $display("FAIL rnd_sel cyc=%0d got=%h exp=%h", cyc, out_sel, es); end
      total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b exp=0", cyc, proto_err); end
      for (int o = 0; o < 5; o++) begin
        if (own[o] >= 0) begin
          if (dv[own[o]] && out_ready[o]) begin
            pos[own[o]]++;
            if (dft[own[o]] == FT_TAIL || dft[own[o]] == FT_SINGLE) begin
              act[own[o]] = 1'b0;
              ptr[o] = (own[o] + 1) % 5;
              own[o] = -1;
            end
          end
        end else begin
          win = -1;
          for (int k = 0; k < 5; k++) begin
            int c;
            c = (ptr[o] + k) % 5;
            if (win < 0 && dv[c] && (dft[c] == FT_HDR || dft[c] == FT_SINGLE) &&
                dest[c] == o + 1 && !eg[c]) win = c;
          end
          own[o] = win;
        end
      end
    end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    out_ready = '1;
    idle_inputs();
    test_reset();
    test_single_packet();
    test_contention();
    test_backpressure();
    test_parallel();
    test_errors();
    test_reset_mid_packet();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-router output-port allocator for the 5-port mesh router (Local, East, North, West, South).
- Each input port presents a flit type and a routed output-port number, as produced by the per-port route compute blocks.
- Per output port: round-robin arbitration among header requests, then wormhole lock to the winner until its tail flit transfers.
- Drives the crossbar select lines and the per-input grant and per-output valid signals.

Parameters:
- NUM_PORTS, 5, number of router ports; fixed at 5, checked at elaboration.
- PORT_W, 4, width of the routed port-number field per input.
- SEL_W, 3, width of the per-output crossbar select (input index 0..4).

Ports:
- clk  in  1  router clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  5  flit valid per input; bit i = input i (0=L, 1=E, 2=N, 3=W, 4=S)
- in_flit_type  in  10  2 bits per input: 10=header, 00=body, 01=tail, 11=single-flit packet
- in_port_num  in  20  PORT_W per input; routed output: 1=L, 2=E, 3=N, 4=W, 5=S
- out_ready  in  5  downstream ready per output
- in_grant  out  5  input i owns an output and may present flits
- out_valid  out  5  flit valid toward downstream per output
- out_sel  out  15  SEL_W per output: owning input index, crossbar select
- out_busy  out  5  output locked to an owner
- proto_err  out  1  sticky protocol-error flag

Behaviour:
- State per output o: IDLE or LOCKED, owner[2:0], and round-robin pointer ptr[2:0].
- Request: input i requests output o when all hold:
  - in_valid[i]
  - flit type is 10 or 11
  - in_port_num[i] == o+1
  - in_grant[i] == 0
- IDLE arbitration: search requesters from ptr upward, mod 5; the first hit wins. Registered: LOCKED and owner = winner on the next edge.
- Latency: header valid at edge N gives in_grant at cycle N+1. The header transfers at the first LOCKED cycle where out_ready is high.
- LOCKED outputs:
  - out_busy[o] = 1
  - out_sel[o] = owner
  - in_grant[owner] = 1
  - out_valid[o] = in_valid[owner] (combinational)
- Transfer: out_valid[o] & out_ready[o].
- Release: a transfer of type 01 or 11 sends the output to IDLE on the next edge and sets ptr = owner+1 mod 5.
- Hold: in_valid low during LOCKED keeps the lock (bubble), and out_valid stays 0.
- Release and new request in the same cycle: the released output takes new requests only from the next edge. One idle cycle per packet boundary is required behaviour.
- Multiple outputs may arbitrate in the same cycle. One input can never hold two outputs, because it presents a single port number.
- IDLE outputs: out_sel = 0, out_busy = 0, out_valid = 0.
- Errors: each of the following sets proto_err, sticky until reset:
  - in_port_num outside 1..5 on a valid header; the flit is ignored and never granted.
  - body or tail valid on an input with in_grant = 0; the flit is ignored.
- Reset (async assert, any time, including mid-packet):
  - all outputs IDLE, ptr = 0, owner = 0
  - in_grant = 0, out_busy = 0, out_valid = 0, out_sel = 0, proto_err = 0
  - partial packets are abandoned.
- Reset deassertion is synchronized by the system; the block acts on the first clk edge after it.

Decomposition:
- Shared package:
  - port codes L=1, E=2, N=3, W=4, S=5
  - flit type codes HDR=2'b10, BODY=2'b00, TAIL=2'b01, SINGLE=2'b11
  - NUM_PORTS
- Sub-module rr_arbiter5:
  - inputs: 5-bit request vector and pointer
  - outputs: one-hot grant and encoded index
  - combinational; one instance per output.
- Lock FSM, pointer and error logic live in switch_allocator.

Test Plan:
- Single packet: input 0 header to port 2 (East), 2 bodies, tail, out_ready=1 -> in_grant[0]=1 from cycle 1; out_sel[1]=0; 4 transfers; out_busy[1] returns to 0 the cycle after the tail.
- Contention: inputs 1, 3, 4 send headers to port 5 at the same time, ptr=0 -> grant order 1, 3, 4. Each packet is followed by one idle cycle; ptr ends at 0.
- Backpressure mid-packet: out_ready=0 for 3 cycles after the header -> lock held, no transfer, tail completes after ready returns; a competing header on input 2 waits and is granted after release.
- Parallel allocation: input 0 to port 3 and input 2 to port 1 in the same cycle -> both granted at cycle 1, independent out_sel values 0 and 2.
- Errors: header with port_num 0 on input 4, and a stray body on ungranted input 1 -> no grants; proto_err=1 and stays set.
- Reset mid-packet: rst low during the body of a locked packet -> all outputs 0 immediately. After release, a new header arbitrates with ptr=0.
